// File: rtl/rob_pkg.sv
// Shared reorder-buffer sizing constants and the entry payload type.
package rob_pkg;

  localparam int unsigned DEPTH    = 32;
  localparam int unsigned TAG_W    = 5;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned NUM_WB   = 4;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned CM_SLOTS = 2;

  typedef struct packed {
    logic              busy;
    logic              done;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] value;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_if.sv
// Dispatch, writeback, flush and commit signals of the reorder buffer.
interface reorder_buffer_if;
  import rob_pkg::*;

  logic                       alloc;
  logic [REG_W-1:0]           alloc_rd;
  logic [TAG_W-1:0]           alloc_tag;
  logic                       full;
  logic                       empty;
  logic [TAG_W:0]             count;
  logic [NUM_WB-1:0]          wb_en;
  logic [NUM_WB*TAG_W-1:0]    wb_tag;
  logic [NUM_WB*DATA_W-1:0]   wb_value;
  logic                       flush;
  logic [CM_SLOTS-1:0]        cm_en;
  logic [CM_SLOTS*REG_W-1:0]  cm_rd;
  logic [CM_SLOTS*TAG_W-1:0]  cm_tag;
  logic [CM_SLOTS*DATA_W-1:0] cm_value;

  modport master (
    output alloc, alloc_rd, wb_en, wb_tag, wb_value, flush,
    input  alloc_tag, full, empty, count, cm_en, cm_rd, cm_tag, cm_value
  );

  modport slave (
    input  alloc, alloc_rd, wb_en, wb_tag, wb_value, flush,
    output alloc_tag, full, empty, count, cm_en, cm_rd, cm_tag, cm_value
  );

endinterface

// File: rtl/rob_commit_select.sv
// In-order two-slot commit selection from the registered head and entry flags.
module rob_commit_select
  import rob_pkg::*;
(
  input  logic [TAG_W-1:0] head,
  input  logic [DEPTH-1:0] busy,
  input  logic [DEPTH-1:0] done,
  output logic [1:0]       commit_c
);

  logic [DEPTH-1:0] ready_c;
  logic [TAG_W-1:0] next_c;
  logic             slot0_c;

  // Slot 1 may only retire when slot 0 retires, keeping commit strictly in order.
  always_comb begin
    ready_c  = busy & done;
    next_c   = TAG_W'(head + TAG_W'(1));
    slot0_c  = ready_c[head];
    commit_c = {slot0_c & ready_c[next_c], slot0_c};
  end

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: dispatch allocation, multi-port writeback, in-order dual commit.
module reorder_buffer #(
  parameter int unsigned DEPTH  = rob_pkg::DEPTH,
  parameter int unsigned TAG_W  = rob_pkg::TAG_W,
  parameter int unsigned DATA_W = rob_pkg::DATA_W,
  parameter int unsigned NUM_WB = rob_pkg::NUM_WB
) (
  input logic             clk,
  input logic             rst,
  reorder_buffer_if.slave bus
);

  localparam int unsigned REG_W = rob_pkg::REG_W;
  localparam int unsigned CNT_W = TAG_W + 1;

  rob_pkg::rob_entry_t entries [DEPTH];

  logic [TAG_W-1:0]  head;
  logic [TAG_W-1:0]  tail;
  logic [CNT_W-1:0]  count;

  logic [DEPTH-1:0]  busy_c;
  logic [DEPTH-1:0]  done_c;
  logic [1:0]        commit_c;
  logic [1:0]        n_commit_c;
  logic [TAG_W-1:0]  head1_c;
  logic              alloc_ok_c;
  logic [DEPTH-1:0]  wb_hit_c;
  logic [DATA_W-1:0] wb_val_c [DEPTH];

  logic [REG_W-1:0]  rd0_c, rd1_c;
  logic [TAG_W-1:0]  tag0_c, tag1_c;
  logic [DATA_W-1:0] val0_c, val1_c;

  // Status outputs come straight from registered state.
  assign bus.alloc_tag = tail;
  assign bus.full      = (count == CNT_W'(DEPTH));
  assign bus.empty     = (count == '0);
  assign bus.count     = count;

  assign alloc_ok_c = bus.alloc & ~bus.full;

  // Flatten entry flags for the commit selector.
  always_comb begin
    busy_c = '0;
    done_c = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      busy_c[i] = entries[i].busy;
      done_c[i] = entries[i].done;
    end
  end

  rob_commit_select u_commit_select (
    .head     (head),
    .busy     (busy_c),
    .done     (done_c),
    .commit_c (commit_c)
  );

  // Commit count and the second-slot index, wrapping at the end of the ring.
  always_comb begin
    head1_c    = TAG_W'(head + TAG_W'(1));
    n_commit_c = {1'b0, commit_c[0]} + {1'b0, commit_c[1]};
  end

  // Per-entry writeback match; the lowest-numbered port that hits a tag wins.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      wb_hit_c[i] = 1'b0;
      wb_val_c[i] = '0;
      for (int unsigned p = 0; p < NUM_WB; p++) begin
        if (!wb_hit_c[i] && bus.wb_en[p] &&
            (bus.wb_tag[p*TAG_W +: TAG_W] == TAG_W'(i))) begin
          wb_hit_c[i] = 1'b1;
          wb_val_c[i] = bus.wb_value[p*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Commit payload for each slot, zero when the slot is idle.
  always_comb begin
    rd0_c  = '0;
    tag0_c = '0;
    val0_c = '0;
    rd1_c  = '0;
    tag1_c = '0;
    val1_c = '0;
    if (commit_c[0]) begin
      rd0_c  = entries[head].rd;
      tag0_c = head;
      val0_c = entries[head].value;
    end
    if (commit_c[1]) begin
      rd1_c  = entries[head1_c].rd;
      tag1_c = head1_c;
      val1_c = entries[head1_c].value;
    end
  end

  // Head/tail/count pointers; flush returns the ring to empty at index 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (bus.flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (alloc_ok_c) begin
        tail <= TAG_W'(tail + TAG_W'(1));
      end
      head  <= TAG_W'(head + TAG_W'(n_commit_c));
      count <= count + CNT_W'(alloc_ok_c) - CNT_W'(n_commit_c);
    end
  end

  // Entry storage: commit frees, allocation claims the tail, writeback marks done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else if (bus.flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entries[i].busy <= 1'b0;
        entries[i].done <= 1'b0;
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if ((commit_c[0] && (TAG_W'(i) == head)) ||
            (commit_c[1] && (TAG_W'(i) == head1_c))) begin
          entries[i].busy <= 1'b0;
          entries[i].done <= 1'b0;
        end else if (alloc_ok_c && (TAG_W'(i) == tail)) begin
          entries[i].busy <= 1'b1;
          entries[i].done <= 1'b0;
          entries[i].rd   <= bus.alloc_rd;
        end else if (wb_hit_c[i] && entries[i].busy) begin
          entries[i].done  <= 1'b1;
          entries[i].value <= wb_val_c[i];
        end
      end
    end
  end

  // Registered one-cycle commit report.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.cm_en    <= '0;
      bus.cm_rd    <= '0;
      bus.cm_tag   <= '0;
      bus.cm_value <= '0;
    end else if (bus.flush) begin
      bus.cm_en    <= '0;
      bus.cm_rd    <= '0;
      bus.cm_tag   <= '0;
      bus.cm_value <= '0;
    end else begin
      bus.cm_en    <= commit_c;
      bus.cm_rd    <= {rd1_c, rd0_c};
      bus.cm_tag   <= {tag1_c, tag0_c};
      bus.cm_value <= {val1_c, val0_c};
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Reorder buffer bench: directed vector table, corner sequences, random traffic vs a queue model.
module tb_reorder_buffer;

  logic clk = 1'b0;
  logic rst;

  reorder_buffer_if rif ();

  reorder_buffer dut (
    .clk (clk),
    .rst (rst),
    .bus (rif)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: program-order queue of in-flight instructions.
  typedef struct {
    logic [4:0]  tag;
    logic [4:0]  rd;
    bit          done;
    logic [31:0] value;
  } ment_t;

  ment_t       q[$];
  int          next_tag;
  logic [1:0]  e_en;
  logic [9:0]  e_rd;
  logic [9:0]  e_tag;
  logic [63:0] e_val;

  typedef struct {
    bit          alloc;
    logic [4:0]  rd;
    int          wb_port;
    logic [4:0]  wtag;
    logic [31:0] wval;
    logic [1:0]  x_en;
    logic [9:0]  x_tag;
    logic [9:0]  x_rd;
    logic [63:0] x_val;
    logic [5:0]  x_count;
    logic [4:0]  x_atag;
  } vec_t;

  vec_t vec [11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit a, int rd, int wp, int wt, logic [31:0] wv,
                              logic [1:0] en, int t0, int rd0, logic [31:0] v0,
                              int cnt, int atag);
    vec_t v;
    v.alloc   = a;
    v.rd      = 5'(rd);
    v.wb_port = wp;
    v.wtag    = 5'(wt);
    v.wval    = wv;
    v.x_en    = en;
    v.x_tag   = {5'd0, 5'(t0)};
    v.x_rd    = {5'd0, 5'(rd0)};
    v.x_val   = {32'd0, v0};
    v.x_count = 6'(cnt);
    v.x_atag  = 5'(atag);
    return v;
  endfunction

  task automatic model_reset();
    q.delete();
    next_tag = 0;
    e_en  = '0;
    e_rd  = '0;
    e_tag = '0;
    e_val = '0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    int pre;
    pre = q.size();
    if (rif.flush) begin
      model_reset();
    end else begin
      e_en  = '0;
      e_rd  = '0;
      e_tag = '0;
      e_val = '0;
      for (int s = 0; s < 2; s++) begin
        if (q.size() > 0 && q[0].done) begin
          e_en[s]          = 1'b1;
          e_rd[s*5 +: 5]   = q[0].rd;
          e_tag[s*5 +: 5]  = q[0].tag;
          e_val[s*32 +: 32] = q[0].value;
          void'(q.pop_front());
        end else begin
          break;
        end
      end
      for (int k = 0; k < q.size(); k++) begin
        ment_t e;
        e = q[k];
        for (int p = 0; p < 4; p++) begin
          if (rif.wb_en[p] && rif.wb_tag[p*5 +: 5] == e.tag) begin
            e.done  = 1'b1;
            e.value = rif.wb_value[p*32 +: 32];
            break;
          end
        end
        q[k] = e;
      end
      if (rif.alloc && pre < 32) begin
        ment_t n;
        n.tag   = 5'(next_tag);
        n.rd    = rif.alloc_rd;
        n.done  = 1'b0;
        n.value = 32'h0;
        q.push_back(n);
        next_tag = (next_tag + 1) % 32;
      end
    end
  endtask

  task automatic check_model();
    chk("m_count", 64'(rif.count), 64'(q.size()));
    chk("m_alloc_tag", 64'(rif.alloc_tag), 64'(next_tag));
    chk("m_full", 64'(rif.full), 64'(q.size() == 32));
    chk("m_empty", 64'(rif.empty), 64'(q.size() == 0));
    chk("m_cm_en", 64'(rif.cm_en), 64'(e_en));
    chk("m_cm_rd", 64'(rif.cm_rd), 64'(e_rd));
    chk("m_cm_tag", 64'(rif.cm_tag), 64'(e_tag));
    chk("m_cm_value", rif.cm_value, e_val);
  endtask

  task automatic clear_in();
    rif.alloc    = 1'b0;
    rif.alloc_rd = '0;
    rif.wb_en    = '0;
    rif.wb_tag   = '0;
    rif.wb_value = '0;
    rif.flush    = 1'b0;
  endtask

  task automatic set_wb(input int p, input int tag, input logic [31:0] v);
    rif.wb_en[p]            = 1'b1;
    rif.wb_tag[p*5 +: 5]    = 5'(tag);
    rif.wb_value[p*32 +: 32] = v;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic alloc_one(input int rd);
    clear_in();
    rif.alloc    = 1'b1;
    rif.alloc_rd = 5'(rd);
    tick();
  endtask

  task automatic idle(input int n);
    clear_in();
    for (int i = 0; i < n; i++) tick();
  endtask

  // Asynchronous reset, checked while asserted, released just after an edge.
  task automatic do_reset();
    rst = 1'b0;
    clear_in();
    model_reset();
    #2;
    chk("rst_count", 64'(rif.count), 64'd0);
    chk("rst_empty", 64'(rif.empty), 64'd1);
    chk("rst_full", 64'(rif.full), 64'd0);
    chk("rst_cm_en", 64'(rif.cm_en), 64'd0);
    chk("rst_cm_value", rif.cm_value, 64'd0);
    chk("rst_alloc_tag", 64'(rif.alloc_tag), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    clear_in();
    model_reset();

    vec[0]  = mk(1, 3, -1, 0, 32'h0,  2'b00, 0, 0, 32'h0,  1, 1);
    vec[1]  = mk(1, 7, -1, 0, 32'h0,  2'b00, 0, 0, 32'h0,  2, 2);
    vec[2]  = mk(1, 9, -1, 0, 32'h0,  2'b00, 0, 0, 32'h0,  3, 3);
    vec[3]  = mk(0, 0,  2, 0, 32'h55, 2'b00, 0, 0, 32'h0,  3, 3);
    vec[4]  = mk(0, 0,  0, 1, 32'hAA, 2'b01, 0, 3, 32'h55, 2, 3);
    vec[5]  = mk(0, 0, -1, 0, 32'h0,  2'b01, 1, 7, 32'hAA, 1, 3);
    vec[6]  = mk(0, 0, -1, 0, 32'h0,  2'b00, 0, 0, 32'h0,  1, 3);
    vec[7]  = mk(0, 0, -1, 0, 32'h0,  2'b00, 0, 0, 32'h0,  1, 3);
    vec[8]  = mk(0, 0,  1, 2, 32'h99, 2'b00, 0, 0, 32'h0,  1, 3);
    vec[9]  = mk(0, 0, -1, 0, 32'h0,  2'b01, 2, 9, 32'h99, 0, 3);
    vec[10] = mk(0, 0, -1, 0, 32'h0,  2'b00, 0, 0, 32'h0,  0, 3);

    do_reset();

    // Directed allocation and single-slot commits from the vector table.
    for (int i = 0; i < 11; i++) begin
      clear_in();
      rif.alloc    = vec[i].alloc;
      rif.alloc_rd = vec[i].rd;
      if (vec[i].wb_port >= 0) set_wb(vec[i].wb_port, int'(vec[i].wtag), vec[i].wval);
      tick();
      chk($sformatf("v%0d_cm_en", i), 64'(rif.cm_en), 64'(vec[i].x_en));
      chk($sformatf("v%0d_cm_tag", i), 64'(rif.cm_tag), 64'(vec[i].x_tag));
      chk($sformatf("v%0d_cm_rd", i), 64'(rif.cm_rd), 64'(vec[i].x_rd));
      chk($sformatf("v%0d_cm_value", i), rif.cm_value, vec[i].x_val);
      chk($sformatf("v%0d_count", i), 64'(rif.count), 64'(vec[i].x_count));
      chk($sformatf("v%0d_alloc_tag", i), 64'(rif.alloc_tag), 64'(vec[i].x_atag));
    end

    // Two entries finishing together retire in a single dual commit.
    do_reset();
    alloc_one(1);
    alloc_one(2);
    clear_in();
    set_wb(0, 0, 32'h10);
    set_wb(1, 1, 32'h20);
    tick();
    idle(1);
    chk("dual_cm_en", 64'(rif.cm_en), 64'b11);
    chk("dual_cm_tag", 64'(rif.cm_tag), 64'({5'd1, 5'd0}));
    chk("dual_cm_rd", 64'(rif.cm_rd), 64'({5'd2, 5'd1}));
    chk("dual_cm_value", rif.cm_value, {32'h20, 32'h10});
    chk("dual_count", 64'(rif.count), 64'd0);

    // Fill to capacity, reject overflow, then dual commit across the wrap.
    do_reset();
    for (int i = 0; i < 32; i++) alloc_one(i);
    chk("fill_full", 64'(rif.full), 64'd1);
    chk("fill_count", 64'(rif.count), 64'd32);
    alloc_one(17);
    chk("ovf_alloc_tag", 64'(rif.alloc_tag), 64'd0);
    chk("ovf_count", 64'(rif.count), 64'd32);
    for (int t = 0; t <= 30; t += 4) begin
      clear_in();
      for (int p = 0; p < 4; p++) begin
        if (t + p <= 30) set_wb(p, t + p, 32'(100 + t + p));
      end
      tick();
    end
    idle(20);
    chk("wrap_pre_count", 64'(rif.count), 64'd1);
    alloc_one(5);
    chk("wrap_new_count", 64'(rif.count), 64'd2);
    clear_in();
    set_wb(0, 31, 32'hC31);
    set_wb(1, 0, 32'hC00);
    tick();
    idle(1);
    chk("wrap_cm_en", 64'(rif.cm_en), 64'b11);
    chk("wrap_cm_tag", 64'(rif.cm_tag), 64'({5'd0, 5'd31}));
    chk("wrap_cm_value", rif.cm_value, {32'hC00, 32'hC31});

    // Port priority on a shared tag, and writeback to a free entry.
    do_reset();
    for (int i = 0; i < 5; i++) alloc_one(10 + i);
    clear_in();
    set_wb(1, 9, 32'h77);
    tick();
    chk("free_wb_count", 64'(rif.count), 64'd5);
    chk("free_wb_cm_en", 64'(rif.cm_en), 64'd0);
    clear_in();
    for (int p = 0; p < 4; p++) set_wb(p, p, 32'(p + 1));
    tick();
    clear_in();
    set_wb(0, 4, 32'h11);
    set_wb(2, 4, 32'h22);
    tick();
    idle(2);
    chk("prio_cm_en", 64'(rif.cm_en), 64'b01);
    chk("prio_cm_tag", 64'(rif.cm_tag[4:0]), 64'd4);
    chk("prio_cm_value", 64'(rif.cm_value[31:0]), 64'h11);
    for (int i = 0; i < 5; i++) alloc_one(20 + i);
    clear_in();
    for (int p = 0; p < 4; p++) set_wb(p, 5 + p, 32'(50 + p));
    tick();
    idle(5);
    chk("free_tag_pending", 64'(rif.count), 64'd1);

    // Flush outranks a ready commit and a simultaneous allocation.
    do_reset();
    for (int i = 0; i < 5; i++) alloc_one(i + 1);
    clear_in();
    set_wb(0, 0, 32'hF0);
    tick();
    clear_in();
    rif.flush    = 1'b1;
    rif.alloc    = 1'b1;
    rif.alloc_rd = 5'd6;
    tick();
    chk("flush_count", 64'(rif.count), 64'd0);
    chk("flush_empty", 64'(rif.empty), 64'd1);
    chk("flush_alloc_tag", 64'(rif.alloc_tag), 64'd0);
    chk("flush_cm_en", 64'(rif.cm_en), 64'd0);
    idle(2);

    // Random traffic with a mid-run asynchronous reset.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) do_reset();
      clear_in();
      rif.alloc    = ($urandom_range(99) < 60);
      rif.alloc_rd = 5'($urandom);
      for (int p = 0; p < 4; p++) begin
        if ($urandom_range(99) < 40) begin
          int tg;
          if (q.size() > 0 && $urandom_range(3) != 0) tg = int'(q[$urandom_range(q.size() - 1)].tag);
          else tg = int'($urandom_range(31));
          set_wb(p, tg, $urandom);
        end
      end
      rif.flush = ($urandom_range(199) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
